// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster counters with blank/line/frame decode and
// a sync delay line that keeps hs/vs aligned with the renderer's lagging colour output.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] hc, vc;
  logic       hs_raw, vs_raw;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= (hc == H_LAST) ? '0 : hc + 10'd1;
      if (hc == H_LAST) vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end
  always_comb begin
    DrawX       = hc;
    DrawY       = vc;
    blank       = (hc < H_VIS) && (vc < V_VIS);
    hs_raw      = !((hc >= HS_BEG) && (hc < HS_END));
    vs_raw      = !((vc >= VS_BEG) && (vc < VS_END));
    line_start  = (hc == '0);
    frame_start = (hc == '0) && (vc == '0);
  end
  generate
    if (SYNC_DELAY == 0) begin : g_direct
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_delay
      // Stages reset to 1 so the sync pins stay inactive until real timing reaches them
      logic [SYNC_DELAY-1:0] hs_q, vs_q;
      always_ff @(posedge vga_clk or negedge reset_n)
        if (!reset_n) begin
          hs_q <= '1;
          vs_q <= '1;
        end else begin
          hs_q <= SYNC_DELAY'({hs_q, hs_raw});
          vs_q <= SYNC_DELAY'({vs_q, vs_raw});
        end
      assign hs = hs_q[SYNC_DELAY-1];
      assign vs = vs_q[SYNC_DELAY-1];
    end
  endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size and shrunken-geometry instances checked every cycle
// against an absolute-time arithmetic model, plus pinned literal timing points.
module tb_vga_timing_gen;
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
  localparam int SVV = 5, SVF = 2, SVS = 2, SVB = 1, SVT = 10;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0, fails = 0;
  int   t = 0;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_bl, a_hs, a_vs, a_ls, a_fs;
  logic b_bl, b_hs, b_vs, b_ls, b_fs;
  logic c_bl, c_hs, c_vs, c_ls, c_fs;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .hs(a_hs), .vs(a_vs), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(3)) dut_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(0)) dut_c (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
    .hs(c_hs), .vs(c_vs), .line_start(c_ls), .frame_start(c_fs));

  // Model time: clock edges seen since the last reset release
  always @(posedge vga_clk or negedge reset_n)
    if (!reset_n) t <= 0;
    else t <= t + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_chk(input string n, input int tm, input int hv, hf, hsw, hb,
                           input int vv, vf, vsw, vb, d,
                           input logic [9:0] dx, dy, input logic bl, h, v, ls, fs);
    int ht, vt, x, y, td;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x  = tm % ht;
    y  = (tm / ht) % vt;
    td = tm - d;
    chk({n, ".DrawX"}, 32'(dx), x);
    chk({n, ".DrawY"}, 32'(dy), y);
    chk({n, ".blank"}, 32'(bl), 32'(x < hv && y < vv));
    chk({n, ".line_start"}, 32'(ls), 32'(x == 0));
    chk({n, ".frame_start"}, 32'(fs), 32'(x == 0 && y == 0));
    chk({n, ".hs"}, 32'(h), 32'(!(td >= 0 && td % ht >= hv + hf && td % ht < hv + hf + hsw)));
    chk({n, ".vs"}, 32'(v), 32'(!(td >= 0 && (td / ht) % vt >= vv + vf &&
                                  (td / ht) % vt < vv + vf + vsw)));
  endtask

  always @(negedge vga_clk) begin
    model_chk("A", t, 640, 16, 96, 48, 480, 10, 2, 33, 2, a_x, a_y, a_bl, a_hs, a_vs, a_ls, a_fs);
    model_chk("B", t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 3, b_x, b_y, b_bl, b_hs, b_vs, b_ls, b_fs);
    model_chk("C", t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, c_x, c_y, c_bl, c_hs, c_vs, c_ls, c_fs);
  end

  task automatic chk_reset_state(input string n, input logic [9:0] dx, dy,
                                 input logic bl, h, v, ls, fs);
    chk({n, ".rst_DrawX"}, 32'(dx), 0);
    chk({n, ".rst_DrawY"}, 32'(dy), 0);
    chk({n, ".rst_blank"}, 32'(bl), 1);
    chk({n, ".rst_hs"}, 32'(h), 1);
    chk({n, ".rst_vs"}, 32'(v), 1);
    chk({n, ".rst_line_start"}, 32'(ls), 1);
    chk({n, ".rst_frame_start"}, 32'(fs), 1);
  endtask

  task automatic async_reset_check;
    reset_n = 1'b0;
    #1;
    chk_reset_state("A", a_x, a_y, a_bl, a_hs, a_vs, a_ls, a_fs);
    chk_reset_state("B", b_x, b_y, b_bl, b_hs, b_vs, b_ls, b_fs);
    chk_reset_state("C", c_x, c_y, c_bl, c_hs, c_vs, c_ls, c_fs);
    repeat ($urandom_range(1, 3)) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int last_fs, last_ls, n;
    repeat (3) @(negedge vga_clk);
    chk_reset_state("A", a_x, a_y, a_bl, a_hs, a_vs, a_ls, a_fs);
    reset_n = 1'b1;
    @(negedge vga_clk);
    chk("A.DrawX_after1", 32'(a_x), 1);
    chk("A.frame_start_after1", 32'(a_fs), 0);
    last_fs = -1;
    last_ls = -1;
    repeat (1000) begin
      @(negedge vga_clk);
      if (t == 657) chk("A.hs@657", 32'(a_hs), 1);
      if (t == 658) chk("A.hs@658", 32'(a_hs), 0);
      if (t == 753) chk("A.hs@753", 32'(a_hs), 0);
      if (t == 754) chk("A.hs@754", 32'(a_hs), 1);
      if (t == 799) chk("A.xy@799", {6'd0, a_y, 6'd0, a_x}, {16'd0, 16'd799});
      if (t == 800) chk("A.xy@800", {6'd0, a_y, 6'd0, a_x}, {16'd1, 16'd0});
      if (t == 107) chk("B.vs@107", 32'(b_vs), 1);
      if (t == 108) chk("B.vs_fall_xy", {b_vs, 1'b0, b_y, 6'd0, b_x}, {1'b0, 1'b0, 10'd7, 6'd0, 10'd3});
      if (t == 9) chk("C.hs@9", 32'(c_hs), 1);
      if (t == 10) chk("C.hs_fall_x", {c_hs, 6'd0, c_x}, {1'b0, 6'd0, 10'd10});
      if (t == 104) chk("C.vs@104", 32'(c_vs), 1);
      if (t == 105) chk("C.vs_fall_xy", {c_vs, 1'b0, c_y, 6'd0, c_x}, {1'b0, 1'b0, 10'd7, 6'd0, 10'd0});
      if (b_fs) begin
        if (last_fs >= 0) chk("B.frame_period", t - last_fs, SHT * SVT);
        last_fs = t;
      end
      if (b_ls) begin
        if (last_ls >= 0) chk("B.line_period", t - last_ls, SHT);
        last_ls = t;
      end
    end
    // Mid-frame reset while B's delayed hs is low (x=13, y=4)
    async_reset_check();
    n = 0;
    while (t != 73 && n < 400) begin
      @(negedge vga_clk);
      n++;
    end
    chk("B.reached_mid_frame", 32'(t), 73);
    chk("B.hs_low_before_reset", 32'(b_hs), 0);
    async_reset_check();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(20, 600)) @(negedge vga_clk);
      @(posedge vga_clk);
      #($urandom_range(1, 4));
      async_reset_check();
    end
    repeat (500) @(negedge vga_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
